reg_op_sequencer: RTL

Multicycle register-operation initiator that drives the 8x8 register file's two read ports and its write port. It accepts one command (opcode, two source registers, destination, immediate), reads the operands, executes the ALU operation, and writes the result back, with a busy/done handshake. It is the master side of the register-file interface, sitting between the control unit and the register bank in the lab CPU datapath.

---
 rtl/reg_op_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/reg_op_sequencer.sv
// Multicycle register-file operation sequencer.
// Reads two operands, runs one ALU op, writes back once.
module reg_op_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] imm,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic [ADDR_W-1:0] ra1,
   output logic [ADDR_W-1:0] ra2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   output logic [ADDR_W-1:0] wa3,
   output logic [DATA_W-1:0] wd3,
   output logic              we3
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_ADDI = 3'b110;
   localparam logic [2:0] OP_NOP  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_EXEC = 3'd2,
      S_WB   = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e state_q, state_d;

   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] rs_q, rs_d;
   logic [ADDR_W-1:0] rt_q, rt_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              zero_q, zero_d;
   logic [ADDR_W-1:0] ra1_q, ra1_d;
   logic [ADDR_W-1:0] ra2_q, ra2_d;
   logic [ADDR_W-1:0] wa3_q, wa3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;
   logic              we3_q, we3_d;
   logic [DATA_W-1:0] alu;
   logic              slt;

   // ALU result for the latched opcode and captured operands
   always_comb begin
      alu = '0;
      slt = $signed(opa_q) < $signed(opb_q);
      unique case (op_q)
         OP_ADD:  alu = opa_q + opb_q;
         OP_SUB:  alu = opa_q - opb_q;
         OP_AND:  alu = opa_q & opb_q;
         OP_OR:   alu = opa_q | opb_q;
         OP_XOR:  alu = opa_q ^ opb_q;
         OP_SLT:  alu = {{(DATA_W-1){1'b0}}, slt};
         OP_ADDI: alu = opa_q + imm_q;
         OP_NOP:  alu = opa_q;
         default: alu = '0;
      endcase
   end

   // Next-state and next-register logic for the sequencer
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      imm_d   = imm_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ra1_d   = ra1_q;
      ra2_d   = ra2_q;
      wa3_d   = wa3_q;
      wd3_d   = wd3_q;
      we3_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               rs_d    = rs;
               rt_d    = rt;
               rd_d    = rd;
               imm_d   = imm;
               ra1_d   = rs;
               ra2_d   = rt;
               state_d = S_READ;
            end
         end
         S_READ: begin
            opa_d   = rd1;
            opb_d   = rd2;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_d   = alu;
            zero_d  = (alu == '0);
            wa3_d   = rd_q;
            wd3_d   = alu;
            // r0 is hardwired and NOP never writes back
            we3_d   = (op_q != OP_NOP) && (rd_q != '0);
            state_d = S_WB;
         end
         S_WB: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b1;
         ra1_q   <= '0;
         ra2_q   <= '0;
         wa3_q   <= '0;
         wd3_q   <= '0;
         we3_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         imm_q   <= imm_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ra1_q   <= ra1_d;
         ra2_q   <= ra2_d;
         wa3_q   <= wa3_d;
         wd3_q   <= wd3_d;
         we3_q   <= we3_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign result = res_q;
   assign zero   = zero_q;
   assign ra1    = ra1_q;
   assign ra2    = ra2_q;
   assign wa3    = wa3_q;
   assign wd3    = wd3_q;
   assign we3    = we3_q;

endmodule
